// File: rtl/stack_ctx_sequencer.sv
// Context save/restore sequencer: streams FIRST_REG..LAST_REG from the register bank onto the
// hardware stack and pops them back in reverse order, while tracking stack occupancy.
module stack_ctx_sequencer #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 15,
    parameter int DEPTH     = 128,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          save_req,
    input  logic          restore_req,
    input  logic          ext_push,
    input  logic          ext_pop,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] level,
    output logic [3:0]    rf_raddr,
    input  logic [31:0]   rf_rdata,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic          stk_push,
    output logic [31:0]   stk_d,
    output logic          stk_pop,
    input  logic [31:0]   stk_q,
    output logic [1:0]    dbg_state
);

    localparam int            N       = LAST_REG - FIRST_REG + 1;
    localparam logic [3:0]    FIRST4  = 4'(FIRST_REG);
    localparam logic [3:0]    LAST4   = 4'(LAST_REG);
    localparam logic [3:0]    LAST_IX = 4'(N - 1);
    localparam logic [LW:0]   N_W     = (LW + 1)'(N);
    localparam logic [LW:0]   DEPTH_W = (LW + 1)'(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAVE    = 2'd1,
        S_RESTORE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n;
    logic          busy_n, done_n, err_n;
    logic [LW-1:0] level_n;
    logic [3:0]    rf_raddr_n, rf_waddr_n;
    logic          rf_we_n, stk_push_n, stk_pop_n;

    logic [LW:0]   lvl_inc, lvl_dec, lvl_up, lvl_net;
    logic          lvl_err;

    // Strobe protocol: stk_push/stk_pop/rf_we are single-cycle strobes with no back-pressure;
    // stk_d and rf_wdata are only meaningful while their strobe is high and read as 0 otherwise.
    assign stk_d     = stk_push ? rf_rdata : 32'h0;
    assign rf_wdata  = rf_we ? stk_q : 32'h0;
    assign dbg_state = state;

    // Occupancy counts every push/pop seen on the stack port, internal or from the pipeline.
    always_comb begin
        lvl_inc = (LW + 1)'(stk_push) + (LW + 1)'(ext_push);
        lvl_dec = (LW + 1)'(stk_pop) + (LW + 1)'(ext_pop);
        lvl_up  = {1'b0, level} + lvl_inc;
        lvl_net = '0;
        lvl_err = 1'b0;
        level_n = level;
        if (lvl_up < lvl_dec) begin
            level_n = '0;
            lvl_err = 1'b1;
        end else begin
            lvl_net = lvl_up - lvl_dec;
            if (lvl_net > DEPTH_W) begin
                level_n = DEPTH_L;
                lvl_err = 1'b1;
            end else begin
                level_n = lvl_net[LW-1:0];
            end
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = err;
        rf_raddr_n = 4'h0;
        rf_waddr_n = 4'h0;
        rf_we_n    = 1'b0;
        stk_push_n = 1'b0;
        stk_pop_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (save_req) begin
                    if ({1'b0, level} + N_W > DEPTH_W) begin
                        err_n  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        state_n    = S_SAVE;
                        idx_n      = 4'h0;
                        busy_n     = 1'b1;
                        err_n      = 1'b0;
                        rf_raddr_n = FIRST4;
                    end
                end else if (restore_req) begin
                    if ({1'b0, level} < N_W) begin
                        err_n  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        state_n   = S_RESTORE;
                        idx_n     = 4'h0;
                        busy_n    = 1'b1;
                        err_n     = 1'b0;
                        stk_pop_n = 1'b1;
                    end
                end
            end

            // Address FIRST_REG+idx is on the bank now; its data arrives next cycle and is pushed then.
            S_SAVE: begin
                stk_push_n = 1'b1;
                if (idx == LAST_IX) begin
                    state_n = S_DRAIN;
                end else begin
                    idx_n      = idx + 4'd1;
                    rf_raddr_n = FIRST4 + idx + 4'd1;
                end
            end

            // The pop issued now returns data next cycle, written to LAST_REG-idx.
            S_RESTORE: begin
                rf_we_n    = 1'b1;
                rf_waddr_n = LAST4 - idx;
                if (idx == LAST_IX) begin
                    state_n = S_DRAIN;
                end else begin
                    idx_n     = idx + 4'd1;
                    stk_pop_n = 1'b1;
                end
            end

            S_DRAIN: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end

            default: state_n = S_IDLE;
        endcase

        if (lvl_err || (busy && (ext_push || ext_pop))) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= 4'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            level    <= '0;
            rf_raddr <= 4'h0;
            rf_waddr <= 4'h0;
            rf_we    <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
            level    <= level_n;
            rf_raddr <= rf_raddr_n;
            rf_waddr <= rf_waddr_n;
            rf_we    <= rf_we_n;
            stk_push <= stk_push_n;
            stk_pop  <= stk_pop_n;
        end
    end

endmodule

// File: tb/tb_stack_ctx_sequencer.sv
// Directed bench for stack_ctx_sequencer: register bank and stack models around the DUT, with a
// scoreboard of expected pushes and register writes checked as the strobes appear.
module tb_stack_ctx_sequencer;

    localparam int FIRST_REG = 1;
    localparam int LAST_REG  = 15;
    localparam int DEPTH     = 128;
    localparam int N         = LAST_REG - FIRST_REG + 1;
    localparam int LW        = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          save_req, restore_req, ext_push, ext_pop;
    logic          busy, done, err;
    logic [LW-1:0] level;
    logic [3:0]    rf_raddr, rf_waddr;
    logic [31:0]   rf_rdata, rf_wdata, stk_d, stk_q;
    logic          rf_we, stk_push, stk_pop;
    logic [1:0]    dbg_state;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Scoreboard entries: {is_write, reg_addr, data}; pushes carry is_write=0 and addr=0.
    logic [36:0]   exp_q[$];
    logic [31:0]   ref_stk[$];
    logic [31:0]   rf_ref[16];
    logic [36:0]   mon_e;

    logic [31:0]   rf_mem[16];
    logic [31:0]   stk_mem[DEPTH];
    int            sp;
    logic          rf_init_req;
    logic [31:0]   rf_init_base;

    stack_ctx_sequencer #(
        .FIRST_REG(FIRST_REG),
        .LAST_REG (LAST_REG),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .save_req   (save_req),
        .restore_req(restore_req),
        .ext_push   (ext_push),
        .ext_pop    (ext_pop),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .level      (level),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stk_push   (stk_push),
        .stk_d      (stk_d),
        .stk_pop    (stk_pop),
        .stk_q      (stk_q),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register bank and stack models ----------------
    always @(posedge clk) begin
        if (rf_init_req) begin
            for (int r = 0; r < 16; r++) rf_mem[r] <= rf_init_base + 32'(r);
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
        if (reset) begin
            rf_rdata <= 32'h0;
            stk_q    <= 32'h0;
            sp       <= 0;
        end else begin
            rf_rdata <= rf_mem[rf_raddr];
            if (stk_push || ext_push) begin
                if (sp < DEPTH) begin
                    stk_mem[sp] <= stk_push ? stk_d : (32'hE000_0000 | 32'(sp));
                    sp <= sp + 1;
                end
            end else if (stk_pop || ext_pop) begin
                if (sp > 0) begin
                    stk_q <= stk_mem[sp-1];
                    sp    <= sp - 1;
                end
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (stk_push) begin
            if (exp_q.size() == 0) begin
                check("push_expected", 64'(stk_push), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("push_data", 64'({1'b0, 4'h0, stk_d}), 64'(mon_e));
            end
        end
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("write_expected", 64'(rf_we), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_write", 64'({1'b1, rf_waddr, rf_wdata}), 64'(mon_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_rf(input logic [31:0] base);
        @(negedge clk);
        rf_init_req  = 1'b1;
        rf_init_base = base;
        @(negedge clk);
        rf_init_req  = 1'b0;
        for (int r = 0; r < 16; r++) rf_ref[r] = base + 32'(r);
    endtask

    task automatic drive_ext_push(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ext_push = 1'b1;
            ref_stk.push_back(32'hE000_0000 | 32'(ref_stk.size()));
        end
        @(negedge clk);
        ext_push = 1'b0;
    endtask

    task automatic drive_ext_pop(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ext_pop = 1'b1;
            if (ref_stk.size() > 0) d = ref_stk.pop_back();
        end
        @(negedge clk);
        ext_pop = 1'b0;
    endtask

    // One request, then cycle-by-cycle checks of the expected timing from T0+1 onward.
    task automatic run_seq(input bit do_save, input bit do_restore);
        bit          acc;
        int          cyc;
        logic [31:0] d;
        acc = do_save ? (ref_stk.size() + N <= DEPTH) : (ref_stk.size() >= N);
        @(negedge clk);
        save_req    = do_save;
        restore_req = do_restore;
        if (acc && do_save) begin
            for (int r = FIRST_REG; r <= LAST_REG; r++) begin
                exp_q.push_back({1'b0, 4'h0, rf_ref[r]});
                ref_stk.push_back(rf_ref[r]);
            end
        end else if (acc) begin
            for (int r = LAST_REG; r >= FIRST_REG; r--) begin
                d = ref_stk.pop_back();
                exp_q.push_back({1'b1, 4'(r), d});
                rf_ref[r] = d;
            end
        end
        cyc = acc ? N + 2 : 3;
        for (int k = 1; k <= cyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                save_req    = 1'b0;
                restore_req = 1'b0;
            end
            if (acc) begin
                check("busy", 64'(busy), 64'(k <= N + 1));
                check("done", 64'(done), 64'(k == N + 2));
                check("stk_push", 64'(stk_push), 64'(do_save && k >= 2 && k <= N + 1));
                check("stk_pop", 64'(stk_pop), 64'(!do_save && k <= N));
                check("rf_we", 64'(rf_we), 64'(!do_save && k >= 2 && k <= N + 1));
                if (do_save && k <= N) check("rf_raddr", 64'(rf_raddr), 64'(FIRST_REG + k - 1));
                if (k == 1) check("err_cleared", 64'(err), 64'(0));
            end else begin
                check("rej_done", 64'(done), 64'(k == 1));
                check("rej_busy", 64'(busy), 64'(0));
                check("rej_strobes", 64'({stk_push, stk_pop, rf_we}), 64'(0));
                check("rej_err", 64'(err), 64'(1));
            end
        end
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("level", 64'(level), 64'(ref_stk.size()));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b1;
        save_req    = 1'b0;
        restore_req = 1'b0;
        ext_push    = 1'b0;
        ext_pop     = 1'b0;
        rf_init_req = 1'b0;
        rf_init_base = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_level", 64'(level), 64'(0));
        check("rst_flags", 64'({busy, done, err}), 64'(0));
        check("rst_strobes", 64'({stk_push, stk_pop, rf_we}), 64'(0));
        check("rst_addr", 64'({rf_raddr, rf_waddr}), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));

        // 1: save r1..r15 = 0x101..0x10F
        load_rf(32'h0000_0100);
        run_seq(1'b1, 1'b0);
        check("t1_level", 64'(level), 64'(15));

        // 2: corrupt the bank, restore brings back 0x10F..0x101 into r15..r1
        load_rf(32'hDEAD_0000);
        run_seq(1'b0, 1'b1);
        check("t2_level", 64'(level), 64'(0));

        // 3: restore on an empty stack is rejected
        run_seq(1'b0, 1'b1);

        // 4: level 120, save would overflow; a restore is then accepted and clears err
        drive_ext_push(120);
        check("t4_level120", 64'(level), 64'(120));
        run_seq(1'b1, 1'b0);
        check("t4_err", 64'(err), 64'(1));
        run_seq(1'b0, 1'b1);
        check("t4_err_clr", 64'(err), 64'(0));
        drive_ext_pop(85);
        check("t4_level20", 64'(level), 64'(20));

        // 5: simultaneous requests, save wins
        run_seq(1'b1, 1'b1);
        check("t5_level", 64'(level), 64'(35));

        // 6: reset in T0+5 of a save
        @(negedge clk);
        save_req = 1'b1;
        for (int r = FIRST_REG; r < FIRST_REG + 4; r++) exp_q.push_back({1'b0, 4'h0, rf_ref[r]});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) save_req = 1'b0;
            if (k == 5) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        ref_stk.delete();
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_level", 64'(level), 64'(0));
        check("t6_state", 64'(dbg_state), 64'(0));
        check("t6_err", 64'(err), 64'(0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t6_quiet", 64'({stk_push, stk_pop, rf_we}), 64'(0));
        end
        check("t6_queue", 64'(exp_q.size()), 64'(0));
        run_seq(1'b1, 1'b0);
        check("t6_level15", 64'(level), 64'(15));
        run_seq(1'b0, 1'b1);

        // ext_pop at level 0 clamps and flags an error
        drive_ext_pop(1);
        check("pop_at_zero_level", 64'(level), 64'(0));
        check("pop_at_zero_err", 64'(err), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
